core_mem_arbiter: RTL
=====================

Name: core_mem_arbiter

Overview:
Parametrised N-master to 1-slave memory command/response arbiter that lets IFU, LSU and future masters share one TCM port. It replaces the fixed point-to-point ifu2itcm/lsu2dtcm wiring. It adds selectable fixed-priority or round-robin arbitration, grant locking under back-pressure, and an in-order outstanding-transaction FIFO that routes each response to its originating master.

Parameters:
N_MST, 2, number of master channels (1..8)
AW, 16, command address width
DW, 32, data width; mask width is DW/8
OUTS_DEPTH, 4, maximum outstanding commands awaiting response (power of 2, >=2)
ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin
IDW, derived, max(1, clog2(N_MST)), master-index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_cmd_valid  in  N_MST  per-master command valid
s_cmd_ready  out  N_MST  per-master command ready
s_cmd_read  in  N_MST  1 = read, 0 = write
s_cmd_addr  in  N_MST*AW  packed addresses, master i at [i*AW +: AW]
s_cmd_wdata  in  N_MST*DW  packed write data
s_cmd_wmask  in  N_MST*DW/8  packed byte masks
s_rsp_valid  out  N_MST  per-master response valid
s_rsp_ready  in  N_MST  per-master response ready
s_rsp_rdata  out  DW  response data, broadcast to all masters, qualified by s_rsp_valid
m_cmd_valid / m_cmd_ready / m_cmd_read / m_cmd_addr / m_cmd_wdata / m_cmd_wmask  out/in/out/out/out/out  1/1/1/AW/DW/DW/8  downstream command
m_rsp_valid  in  1  downstream response valid
m_rsp_ready  out  1  downstream response ready
m_rsp_rdata  in  DW  downstream response data
outs_cnt  out  clog2(OUTS_DEPTH)+1  commands currently outstanding
idle  out  1  outs_cnt==0 and no s_cmd_valid asserted

Behaviour:
- Reset (async, rst=1): FIFO empty, outs_cnt=0, round-robin pointer=0, lock cleared. All of m_cmd_valid, s_cmd_ready, s_rsp_valid and m_rsp_ready are 0 while rst=1. idle=1 after reset when no s_cmd_valid is asserted.
- Every command, read or write, produces exactly one downstream response. Responses return in command order.
- Arbitration is combinational with zero added latency: m_cmd_valid = |s_cmd_valid && !full.
- ARB_MODE 0: lowest asserted index wins.
- ARB_MODE 1: search starts at the pointer. The pointer moves to (winner+1) mod N_MST on each m_cmd handshake only.
- Lock: if m_cmd_valid && !m_cmd_ready, register lock=1 with locked_idx=winner. While lock=1 the grant is forced to locked_idx, so payload stays stable even if a higher-priority master asserts. The lock clears on the handshake.
- A master that drops valid while locked is a protocol violation. The arbiter does not handle it; covered by an assertion.
- s_cmd_ready[i] = m_cmd_ready && grant==i && !full. Only one bit is set at a time.
- Outstanding FIFO: depth OUTS_DEPTH, entry width IDW. On an m_cmd handshake, push the grant index.
- full = (outs_cnt==OUTS_DEPTH). When full, commands are blocked even if a pop occurs in the same cycle; there is no bypass.
- Response routing uses the head index h: s_rsp_valid[h] = m_rsp_valid && !empty, and m_rsp_ready = s_rsp_ready[h] && !empty. Pop on the m_rsp handshake.
- An m_rsp_valid arriving with the FIFO empty is not acknowledged (m_rsp_ready=0). Covered by an assertion.
- Simultaneous push and pop: outs_cnt is unchanged and both pointers advance. Pointers wrap mod OUTS_DEPTH.
- Minimum round trip is 1 cycle (SRAM-style response in the cycle after cmd). Back-to-back commands are supported at 1 per cycle until full.
- N_MST=1: the arbiter degenerates to a pass-through plus the outstanding limiter; the grant is always 0.

Decomposition:
- Shared defines file: ARB_FIXED/ARB_RR mode constants and the IDW derivation macro. No new typedefs.
- One sub-module: core_arb_fifo, a sync FIFO (DEPTH, DW params, push/pop/full/empty/count) holding master indices. It is reusable for the LSU itag queue.

Test Plan:
- N_MST=2, RR: both masters assert valid for 4 cycles with m_cmd_ready=1, 1-cycle responses -> grants 0,1,0,1; rsp to masters 0,1,0,1 with matching rdata.
- ARB_MODE 0: both valid continuously -> master 0 granted every cycle and master 1 starved; master 1 is granted the cycle after master 0 drops.
- Lock: m_cmd_ready=0, master 1 alone valid for 1 cycle, then master 0 asserts -> grant stays 1 and m_cmd_addr is stable until ready; the next grant goes to 0.
- Outstanding limit, OUTS_DEPTH=4, m_rsp held low: 4 commands accepted, outs_cnt=4, m_cmd_valid=0. Then one response plus a pending cmd in the same cycle -> cmd blocked that cycle and accepted the next cycle.
- Response back-pressure: head master's s_rsp_ready=0 -> m_rsp_ready=0 and the FIFO is not popped; releasing it pops and delivers the response to the correct master.
- Reset mid-operation: rst asserted with outs_cnt=3 and lock=1 -> all valids/readies 0 immediately (async), outs_cnt=0, idle=1 after release, RR pointer=0.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants for the core memory arbiter: arbitration modes and the
// master-index width derivation.
package core_mem_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Master-index width; a single master still needs one bit of storage.
  function automatic int idw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/core_arb_fifo.sv
// Small synchronous FIFO with occupancy count; holds master indices for
// in-order response routing (also usable as an LSU itag queue).
module core_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// N-master to 1-slave TCM command/response arbiter with fixed or round-robin
// grant, grant lock under back-pressure and in-order response routing.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int N_MST      = 2,
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int ARB_MODE   = ARB_RR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MST-1:0]          s_cmd_valid,
  output logic [N_MST-1:0]          s_cmd_ready,
  input  logic [N_MST-1:0]          s_cmd_read,
  input  logic [N_MST*AW-1:0]       s_cmd_addr,
  input  logic [N_MST*DW-1:0]       s_cmd_wdata,
  input  logic [N_MST*(DW/8)-1:0]   s_cmd_wmask,
  output logic [N_MST-1:0]          s_rsp_valid,
  input  logic [N_MST-1:0]          s_rsp_ready,
  output logic [DW-1:0]             s_rsp_rdata,
  output logic                      m_cmd_valid,
  input  logic                      m_cmd_ready,
  output logic                      m_cmd_read,
  output logic [AW-1:0]             m_cmd_addr,
  output logic [DW-1:0]             m_cmd_wdata,
  output logic [DW/8-1:0]           m_cmd_wmask,
  input  logic                      m_rsp_valid,
  output logic                      m_rsp_ready,
  input  logic [DW-1:0]             m_rsp_rdata,
  output logic [$clog2(OUTS_DEPTH):0] outs_cnt,
  output logic                      idle
);

  localparam int IDW = idw_of(N_MST);
  localparam int MW  = DW/8;

  logic [IDW-1:0] winner, grant, locked_idx, rr_ptr, rr_next, start, head;
  logic           lock, full, empty, any_valid, cmd_hs, rsp_hs, head_rdy;

  assign any_valid = |s_cmd_valid;

  // Fixed priority is a round-robin search that always starts at master 0.
  assign start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  always_comb begin
    winner = '0;
    for (int k = N_MST-1; k >= 0; k--) begin
      int idx;
      idx = int'(start) + k;
      if (idx >= N_MST) idx = idx - N_MST;
      if (s_cmd_valid[idx]) winner = IDW'(idx);
    end
  end

  assign grant       = lock ? locked_idx : winner;
  assign m_cmd_valid = !rst && any_valid && !full;
  assign cmd_hs      = m_cmd_valid && m_cmd_ready;
  assign rr_next     = (grant == IDW'(N_MST-1)) ? '0 : grant + 1'b1;

  always_comb begin
    m_cmd_read  = 1'b0;
    m_cmd_addr  = '0;
    m_cmd_wdata = '0;
    m_cmd_wmask = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (grant == IDW'(i)) begin
        m_cmd_read  = s_cmd_read[i];
        m_cmd_addr  = s_cmd_addr[i*AW +: AW];
        m_cmd_wdata = s_cmd_wdata[i*DW +: DW];
        m_cmd_wmask = s_cmd_wmask[i*MW +: MW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      locked_idx <= '0;
      rr_ptr     <= '0;
    end else if (cmd_hs) begin
      lock   <= 1'b0;
      rr_ptr <= rr_next;
    end else if (m_cmd_valid) begin
      // Stalled offer: freeze the grant so the payload cannot change under it.
      lock       <= 1'b1;
      locked_idx <= grant;
    end
  end

  core_arb_fifo #(.DEPTH(OUTS_DEPTH), .DW(IDW)) u_outs (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_hs),
    .pop   (rsp_hs),
    .din   (grant),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outs_cnt)
  );

  always_comb begin
    head_rdy = 1'b0;
    for (int i = 0; i < N_MST; i++)
      if (head == IDW'(i)) head_rdy = s_rsp_ready[i];
  end

  for (genvar i = 0; i < N_MST; i++) begin : g_mst
    assign s_cmd_ready[i] = !rst && m_cmd_ready && !full && (grant == IDW'(i));
    assign s_rsp_valid[i] = !rst && m_rsp_valid && !empty && (head == IDW'(i));
  end

  assign m_rsp_ready = !rst && !empty && head_rdy;
  assign rsp_hs      = m_rsp_valid && m_rsp_ready;
  assign s_rsp_rdata = m_rsp_rdata;
  assign idle        = (outs_cnt == '0) && !any_valid;

  a_lock_hold: assert property (@(posedge clk) disable iff (rst)
    lock |-> s_cmd_valid[locked_idx]);
  a_rsp_orphan: assert property (@(posedge clk) disable iff (rst)
    m_rsp_valid |-> !empty);

endmodule
